// File: rtl/gelato_pkg.sv
// Shared types and default widths for the Gelato SIMT reconvergence stack.
package gelato_pkg;

  localparam int GELATO_ADDR_WIDTH = 32;
  localparam int GELATO_WARP_SIZE  = 32;

  // Operation codes issued by instruction decode.
  typedef enum logic [1:0] {
    SIMT_INIT  = 2'd0,
    SIMT_SPLIT = 2'd1,
    SIMT_JOIN  = 2'd2
  } simt_op_e;

  // One reconvergence stack entry at the default widths.
  typedef struct packed {
    logic [GELATO_ADDR_WIDTH-1:0] pc;
    logic [GELATO_WARP_SIZE-1:0]  mask;
  } simt_entry_t;

endpackage

// File: rtl/gelato_simt_stack_mem.sv
// Per-warp reconvergence stack storage. Two write ports target consecutive
// entries of one warp so a divergent split pushes both entries in one cycle.
// Contents carry no reset; stack pointers in the parent qualify validity.
module gelato_simt_stack_mem #(
  parameter int NUM_WARPS   = 8,
  parameter int WARP_SIZE   = 32,
  parameter int STACK_DEPTH = 8,
  parameter int ADDR_WIDTH  = 32,
  localparam int WW = $clog2(NUM_WARPS),
  localparam int IW = $clog2(STACK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WW-1:0]         wr_warp,
  input  logic [IW-1:0]         wr_idx,
  input  logic [ADDR_WIDTH-1:0] wr_pc0,
  input  logic [WARP_SIZE-1:0]  wr_mask0,
  input  logic [ADDR_WIDTH-1:0] wr_pc1,
  input  logic [WARP_SIZE-1:0]  wr_mask1,
  input  logic [WW-1:0]         rd_warp,
  input  logic [IW-1:0]         rd_idx,
  output logic [ADDR_WIDTH-1:0] rd_pc,
  output logic [WARP_SIZE-1:0]  rd_mask
);

  logic [ADDR_WIDTH-1:0] pc_mem   [NUM_WARPS][STACK_DEPTH];
  logic [WARP_SIZE-1:0]  mask_mem [NUM_WARPS][STACK_DEPTH];
  logic [IW-1:0]         wr_idx1;

  assign wr_idx1 = wr_idx + IW'(1);

  // Paired push: port 0 at wr_idx, port 1 at wr_idx+1.
  always_ff @(posedge clk) begin
    if (we) begin
      pc_mem[wr_warp][wr_idx]    <= wr_pc0;
      mask_mem[wr_warp][wr_idx]  <= wr_mask0;
      pc_mem[wr_warp][wr_idx1]   <= wr_pc1;
      mask_mem[wr_warp][wr_idx1] <= wr_mask1;
    end
  end

  // Combinational read of the top-of-stack entry.
  always_comb begin
    rd_pc   = pc_mem[rd_warp][rd_idx];
    rd_mask = mask_mem[rd_warp][rd_idx];
  end

endmodule

// File: rtl/gelato_simt_stack.sv
// Per-warp SIMT reconvergence stack: handles INIT/SPLIT/JOIN from decode and
// produces a registered next-PC / active-mask update for the PC table.
module gelato_simt_stack
  import gelato_pkg::*;
#(
  parameter int NUM_WARPS   = 8,
  parameter int WARP_SIZE   = GELATO_WARP_SIZE,
  parameter int STACK_DEPTH = 8,
  parameter int ADDR_WIDTH  = GELATO_ADDR_WIDTH,
  localparam int WW = $clog2(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [1:0]            op_kind,
  input  logic [WW-1:0]         op_warp,
  input  logic [WARP_SIZE-1:0]  op_mask,
  input  logic [ADDR_WIDTH-1:0] op_pc,
  input  logic [ADDR_WIDTH-1:0] op_fall_pc,
  input  logic [ADDR_WIDTH-1:0] op_reconv_pc,
  output logic                  upd_valid,
  output logic [WW-1:0]         upd_warp,
  output logic [ADDR_WIDTH-1:0] upd_pc,
  output logic [WARP_SIZE-1:0]  upd_mask,
  output logic [NUM_WARPS-1:0]  err_overflow,
  output logic [NUM_WARPS-1:0]  err_underflow
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);
  // Highest sp at which a two-entry push still fits.
  localparam logic [SPW-1:0] SP_PUSH_MAX = SPW'(STACK_DEPTH - 2);

  logic [WARP_SIZE-1:0]  act_q [NUM_WARPS];
  logic [SPW-1:0]        sp_q  [NUM_WARPS];
  logic [NUM_WARPS-1:0]  ovf_q, unf_q;

  logic                  upd_valid_q;
  logic [WW-1:0]         upd_warp_q;
  logic [ADDR_WIDTH-1:0] upd_pc_q;
  logic [WARP_SIZE-1:0]  upd_mask_q;

  simt_op_e              kind;
  logic                  accept;
  logic [WARP_SIZE-1:0]  cur_act, taken, fall;
  logic [SPW-1:0]        cur_sp;
  logic [IW-1:0]         rd_idx;
  logic [ADDR_WIDTH-1:0] rd_pc;
  logic [WARP_SIZE-1:0]  rd_mask;

  logic [WARP_SIZE-1:0]  nxt_act;
  logic [SPW-1:0]        nxt_sp;
  logic                  emit, push, set_ovf, set_unf, clr_err;
  logic [ADDR_WIDTH-1:0] emit_pc;
  logic [WARP_SIZE-1:0]  emit_mask;

  assign op_ready = rdy;
  assign accept   = op_valid & rdy;
  assign kind     = simt_op_e'(op_kind);

  assign cur_act = act_q[op_warp];
  assign cur_sp  = sp_q[op_warp];
  assign taken   = op_mask & cur_act;
  assign fall    = ~op_mask & cur_act;
  assign rd_idx  = IW'(cur_sp - SPW'(1));

  gelato_simt_stack_mem #(
    .NUM_WARPS   (NUM_WARPS),
    .WARP_SIZE   (WARP_SIZE),
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_mem (
    .clk      (clk),
    .we       (push),
    .wr_warp  (op_warp),
    .wr_idx   (IW'(cur_sp)),
    .wr_pc0   (op_reconv_pc),
    .wr_mask0 (cur_act),
    .wr_pc1   (op_fall_pc),
    .wr_mask1 (fall),
    .rd_warp  (op_warp),
    .rd_idx   (rd_idx),
    .rd_pc    (rd_pc),
    .rd_mask  (rd_mask)
  );

  // Decode the accepted operation into next warp state and the update value.
  always_comb begin
    nxt_act   = cur_act;
    nxt_sp    = cur_sp;
    emit      = 1'b0;
    emit_pc   = '0;
    emit_mask = '0;
    push      = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    clr_err   = 1'b0;
    if (accept) begin
      case (kind)
        SIMT_INIT: begin
          nxt_act   = op_mask;
          nxt_sp    = '0;
          clr_err   = 1'b1;
          emit      = 1'b1;
          emit_pc   = op_pc;
          emit_mask = op_mask;
        end
        SIMT_SPLIT: begin
          emit = 1'b1;
          if (taken == '0) begin
            emit_pc   = op_fall_pc;
            emit_mask = cur_act;
          end else if (fall == '0) begin
            emit_pc   = op_pc;
            emit_mask = cur_act;
          end else if (cur_sp <= SP_PUSH_MAX) begin
            push      = 1'b1;
            nxt_sp    = cur_sp + SPW'(2);
            nxt_act   = taken;
            emit_pc   = op_pc;
            emit_mask = taken;
          end else begin
            // No room for both entries: run the taken path with the full mask.
            set_ovf   = 1'b1;
            emit_pc   = op_pc;
            emit_mask = cur_act;
          end
        end
        SIMT_JOIN: begin
          if (cur_sp != '0) begin
            nxt_act   = rd_mask;
            nxt_sp    = cur_sp - SPW'(1);
            emit      = 1'b1;
            emit_pc   = rd_pc;
            emit_mask = rd_mask;
          end else begin
            set_unf = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-warp active mask and stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        act_q[w] <= '0;
        sp_q[w]  <= '0;
      end
    end else if (accept) begin
      act_q[op_warp] <= nxt_act;
      sp_q[op_warp]  <= nxt_sp;
    end
  end

  // Sticky error flags; INIT of a warp clears its own flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
      unf_q <= '0;
    end else if (accept) begin
      if (clr_err) begin
        ovf_q[op_warp] <= 1'b0;
        unf_q[op_warp] <= 1'b0;
      end
      if (set_ovf) ovf_q[op_warp] <= 1'b1;
      if (set_unf) unf_q[op_warp] <= 1'b1;
    end
  end

  // Registered update; holds while rdy is low so a pending update is delayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_q <= 1'b0;
      upd_warp_q  <= '0;
      upd_pc_q    <= '0;
      upd_mask_q  <= '0;
    end else if (rdy) begin
      upd_valid_q <= emit;
      if (emit) begin
        upd_warp_q <= op_warp;
        upd_pc_q   <= emit_pc;
        upd_mask_q <= emit_mask;
      end
    end
  end

  assign upd_valid     = upd_valid_q & rdy;
  assign upd_warp      = upd_warp_q;
  assign upd_pc        = upd_pc_q;
  assign upd_mask      = upd_mask_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_gelato_simt_stack.sv
// Scoreboard bench for gelato_simt_stack with STACK_DEPTH = 4.
module tb_gelato_simt_stack;
  import gelato_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_kind = 2'd0;
  logic [2:0]  op_warp = 3'd0;
  logic [31:0] op_mask = '0, op_pc = '0, op_fall_pc = '0, op_reconv_pc = '0;
  logic        upd_valid;
  logic [2:0]  upd_warp;
  logic [31:0] upd_pc, upd_mask;
  logic [7:0]  err_overflow, err_underflow;

  typedef struct {
    logic [2:0]  w;
    logic [31:0] pc;
    logic [31:0] mask;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  gelato_simt_stack #(
    .NUM_WARPS(8), .WARP_SIZE(32), .STACK_DEPTH(4), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
    .op_warp(op_warp), .op_mask(op_mask), .op_pc(op_pc),
    .op_fall_pc(op_fall_pc), .op_reconv_pc(op_reconv_pc),
    .upd_valid(upd_valid), .upd_warp(upd_warp), .upd_pc(upd_pc),
    .upd_mask(upd_mask), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented update must match the oldest expectation.
  always @(negedge clk) begin
    if (upd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: got w=%0d pc=%h mask=%h cyc=%0d, required none",
                 upd_warp, upd_pc, upd_mask, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (upd_warp !== e.w || upd_pc !== e.pc || upd_mask !== e.mask || cyc != e.cyc) begin
          errors++;
          $display("FAIL update: got w=%0d pc=%h mask=%h cyc=%0d, required w=%0d pc=%h mask=%h cyc=%0d",
                   upd_warp, upd_pc, upd_mask, cyc, e.w, e.pc, e.mask, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // Drive one operation, wait for its accepting edge, and record the expected update.
  task automatic issue(input simt_op_e k, input logic [2:0] w, input logic [31:0] m,
                       input logic [31:0] pc, input logic [31:0] fpc, input logic [31:0] rpc,
                       input bit ev, input logic [31:0] epc, input logic [31:0] emask);
    exp_t e;
    op_kind = k; op_warp = w; op_mask = m;
    op_pc = pc; op_fall_pc = fpc; op_reconv_pc = rpc;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (ev) begin
      e.w = w; e.pc = epc; e.mask = emask; e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    #1;
    chk("reset_upd_valid", 64'(upd_valid), 64'd0);
    chk("reset_upd_pc", 64'(upd_pc), 64'd0);
    chk("reset_upd_mask", 64'(upd_mask), 64'd0);
    chk("reset_errs", 64'({err_overflow, err_underflow}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // INIT then uniform branches on warp 2.
    issue(SIMT_INIT,  3'd2, 32'hFFFF_FFFF, 32'h100, 32'h0,   32'h0,   1, 32'h100, 32'hFFFF_FFFF);
    issue(SIMT_SPLIT, 3'd2, 32'h0,         32'h1F0, 32'h104, 32'h300, 1, 32'h104, 32'hFFFF_FFFF);
    issue(SIMT_SPLIT, 3'd2, 32'hFFFF_FFFF, 32'h108, 32'h10C, 32'h300, 1, 32'h108, 32'hFFFF_FFFF);

    // Divergent split and two joins, back to back.
    issue(SIMT_SPLIT, 3'd2, 32'h0000_FFFF, 32'h200, 32'h180, 32'h300, 1, 32'h200, 32'h0000_FFFF);
    issue(SIMT_JOIN,  3'd2, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h180, 32'hFFFF_0000);
    issue(SIMT_JOIN,  3'd2, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h300, 32'hFFFF_FFFF);

    // Underflow: no update, sticky flag.
    issue(SIMT_JOIN,  3'd2, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    chk("underflow_no_update", 64'(upd_valid), 64'd0);
    chk("underflow_flag", 64'(err_underflow), 64'h04);

    // Nested divergence to overflow on warp 3 (op_mask bits outside act ignored).
    issue(SIMT_INIT,  3'd3, 32'h0000_00FF, 32'h400, 32'h0,   32'h0,   1, 32'h400, 32'h0000_00FF);
    issue(SIMT_SPLIT, 3'd3, 32'hFFFF_FFF0, 32'h500, 32'h480, 32'h600, 1, 32'h500, 32'h0000_00F0);
    issue(SIMT_SPLIT, 3'd3, 32'h0000_0030, 32'h510, 32'h520, 32'h530, 1, 32'h510, 32'h0000_0030);
    issue(SIMT_SPLIT, 3'd3, 32'h0000_0010, 32'h540, 32'h550, 32'h560, 1, 32'h540, 32'h0000_0030);
    chk("overflow_flag", 64'(err_overflow), 64'h08);
    // sp = 3 boundary: a divergent split must also overflow with no partial push.
    issue(SIMT_JOIN,  3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h520, 32'h0000_00C0);
    issue(SIMT_SPLIT, 3'd3, 32'h0000_0040, 32'h570, 32'h580, 32'h590, 1, 32'h570, 32'h0000_00C0);
    issue(SIMT_JOIN,  3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h530, 32'h0000_00F0);
    issue(SIMT_JOIN,  3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h480, 32'h0000_000F);
    issue(SIMT_JOIN,  3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h600, 32'h0000_00FF);
    chk("overflow_sticky", 64'(err_overflow), 64'h08);

    // Re-INIT of warp 2 clears its underflow flag.
    issue(SIMT_INIT,  3'd2, 32'h0000_0001, 32'h700, 32'h0, 32'h0, 1, 32'h700, 32'h0000_0001);
    chk("init_clears_underflow", 64'(err_underflow), 64'h00);

    // Interleaved warps: split on warp 0, then underflowing join on warp 1.
    issue(SIMT_INIT,  3'd0, 32'hFFFF_FFFF, 32'h800, 32'h0,   32'h0,   1, 32'h800, 32'hFFFF_FFFF);
    issue(SIMT_SPLIT, 3'd0, 32'h0000_000F, 32'h900, 32'h880, 32'h9F0, 1, 32'h900, 32'h0000_000F);
    issue(SIMT_JOIN,  3'd1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    chk("interleave_underflow", 64'(err_underflow), 64'h02);
    issue(SIMT_JOIN,  3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h880, 32'hFFFF_FFF0);
    issue(SIMT_JOIN,  3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h9F0, 32'hFFFF_FFFF);

    // rdy drop after an accepted split: update held for three cycles.
    issue(SIMT_INIT,  3'd4, 32'hFFFF_FFFF, 32'hA00, 32'h0, 32'h0, 1, 32'hA00, 32'hFFFF_FFFF);
    op_kind = SIMT_SPLIT; op_warp = 3'd4; op_mask = 32'h0000_FF00;
    op_pc = 32'hB00; op_fall_pc = 32'hA80; op_reconv_pc = 32'hC00;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    rdy = 1'b0;
    e.w = 3'd4; e.pc = 32'hB00; e.mask = 32'h0000_FF00; e.cyc = cyc + 3;
    sb.push_back(e);
    #1;
    chk("rdy_low_op_ready", 64'(op_ready), 64'd0);
    chk("rdy_low_upd_valid", 64'(upd_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rdy_low_held_upd_pc", 64'(upd_pc), 64'hB00);
    rdy = 1'b1;
    @(posedge clk); #1;

    // Reset mid-stream discards the in-flight update at once.
    issue(SIMT_INIT, 3'd5, 32'h0000_00FF, 32'hD00, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    chk("inflight_before_reset", 64'(upd_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_upd_valid", 64'(upd_valid), 64'd0);
    chk("async_rst_upd_pc_mask", {upd_pc, upd_mask}, 64'd0);
    chk("async_rst_errs", 64'({err_overflow, err_underflow}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Stack pointers were cleared: a join on warp 2 underflows.
    issue(SIMT_JOIN, 3'd2, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    chk("post_reset_underflow", 64'(err_underflow), 64'h04);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
